// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// calc_pkg : shared types and constants for the keypad calculator sequencer
// Rev 1.0
// ============================================================================
package calc_pkg;

    typedef enum logic [7:0] {
        ENTA = 8'b0000_0001,
        ENTB = 8'b0000_0010,
        LDA  = 8'b0000_0100,
        LDB  = 8'b0000_1000,
        LDS  = 8'b0001_0000,
        WAIT = 8'b0010_0000,
        SHOW = 8'b0100_0000,
        ERR  = 8'b1000_0000
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_EQ  = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;

    localparam logic [1:0] DISP_A = 2'd0;
    localparam logic [1:0] DISP_B = 2'd1;
    localparam logic [1:0] DISP_S = 2'd2;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage
`default_nettype wire

// File: rtl/module_digit_reg.sv
`default_nettype none
// ============================================================================
// module_digit_reg : BCD shift register holding up to NDIG digits plus count
// Rev 1.0
// ============================================================================
module module_digit_reg #(
    parameter int NDIG = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic [3:0]        din,
    output logic [4*NDIG-1:0] q,
    output logic              full
);

    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);

    logic [W-1:0]  q_q, q_d, w_shifted;
    logic [CW-1:0] cnt_q, cnt_d;

    generate
        if (NDIG == 1) begin : g_single
            assign w_shifted = din;
        end else begin : g_multi
            assign w_shifted = {q_q[W-5:0], din};
        end
    endgenerate

    assign full = (cnt_q == CW'(NDIG));
    assign q    = q_q;

    // clr together with shift restarts the operand with din as its first digit
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (clr) begin
            q_d   = '0;
            cnt_d = '0;
        end
        if (shift && clr) begin
            q_d   = W'(din);
            cnt_d = CW'(1);
        end else if (shift && !full) begin
            q_d   = w_shifted;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/module_calc_ctrl.sv
`default_nettype none
// ============================================================================
// module_calc_ctrl : key-driven sequencer for the BCD adder/display datapath
// Rev 1.0
// ============================================================================
module module_calc_ctrl
    import calc_pkg::*;
#(
    parameter int NDIG    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              s_done,
    output logic [4*NDIG-1:0] opa,
    output logic [4*NDIG-1:0] opb,
    output logic              load_a,
    output logic              load_b,
    output logic              load_s,
    output logic [1:0]        disp_sel,
    output logic              busy,
    output logic              ovf,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ovf_q, ovf_d;
    logic          clr_ops, shift_a, shift_b, full_a, full_b;

    wire key_clr = key_valid && (key_code == KEY_CLR);
    wire key_add = key_valid && (key_code == KEY_ADD);
    wire key_eq  = key_valid && (key_code == KEY_EQ);
    wire key_dig = key_valid && is_digit(key_code);

    module_digit_reg #(.NDIG(NDIG)) u_reg_a (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_ops),
        .shift (shift_a),
        .din   (key_code),
        .q     (opa),
        .full  (full_a)
    );

    module_digit_reg #(.NDIG(NDIG)) u_reg_b (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_ops),
        .shift (shift_b),
        .din   (key_code),
        .q     (opb),
        .full  (full_b)
    );

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        clr_ops = 1'b0;
        shift_a = 1'b0;
        shift_b = 1'b0;
        tmo_d   = (state_q == WAIT) ? tmo_q + TW'(1) : '0;
        if (key_clr) begin
            clr_ops = 1'b1;
            ovf_d   = 1'b0;
            state_d = ENTA;
        end else begin
            case (state_q)
                ENTA: begin
                    if (key_dig) begin
                        shift_a = 1'b1;
                        ovf_d   = ovf_q | full_a;
                    end else if (key_add) begin
                        state_d = ENTB;
                    end
                end
                ENTB: begin
                    if (key_dig) begin
                        shift_b = 1'b1;
                        ovf_d   = ovf_q | full_b;
                    end else if (key_eq) begin
                        state_d = LDA;
                    end
                end
                LDA:  state_d = LDB;
                LDB:  state_d = LDS;
                LDS:  state_d = WAIT;
                // s_done takes precedence over an expiring timeout
                WAIT: begin
                    if (s_done)
                        state_d = SHOW;
                    else if (tmo_q == TW'(TIMEOUT - 1))
                        state_d = ERR;
                end
                SHOW: begin
                    if (key_dig) begin
                        clr_ops = 1'b1;
                        shift_a = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = ENTA;
                    end
                end
                ERR:     state_d = ERR;
                default: state_d = ENTA;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ENTA;
            tmo_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            ovf_q   <= ovf_d;
        end
    end

    // All outputs decode the state register so reset removes strobes at once
    assign load_a = (state_q == LDA);
    assign load_b = (state_q == LDB);
    assign load_s = (state_q == LDS);
    assign busy   = (state_q == LDA) || (state_q == LDB) ||
                    (state_q == LDS) || (state_q == WAIT);
    assign err    = (state_q == ERR);
    assign ovf    = ovf_q;

    always_comb begin
        case (state_q)
            ENTA:       disp_sel = DISP_A;
            SHOW, ERR:  disp_sel = DISP_S;
            default:    disp_sel = DISP_B;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_module_calc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_module_calc_ctrl : directed and random checks of the calculator sequencer
// Rev 1.0
// ============================================================================
module tb_module_calc_ctrl;

    localparam int NDIG = 3;
    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_EQ  = 4'hB;
    localparam logic [3:0] K_CLR = 4'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        s_done = 1'b0;
    logic        s_done2 = 1'b0;

    logic [4*NDIG-1:0] opa, opb, opa2, opb2;
    logic        load_a, load_b, load_s, busy, ovf, err;
    logic        la2, lb2, ls2, busy2, ovf2, err2;
    logic [1:0]  disp_sel, ds2;

    int nchk = 0;
    int nerr = 0;

    // reference model state: entered digits as plain lists, mode 0=A 1=B 2=result
    int qa[$];
    int qb[$];
    bit m_ovf;
    int mode;

    module_calc_ctrl #(.NDIG(NDIG), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .s_done(s_done), .opa(opa), .opb(opb), .load_a(load_a),
        .load_b(load_b), .load_s(load_s), .disp_sel(disp_sel), .busy(busy),
        .ovf(ovf), .err(err)
    );

    module_calc_ctrl #(.NDIG(NDIG), .TIMEOUT(4)) dut_t4 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .s_done(s_done2), .opa(opa2), .opb(opb2), .load_a(la2),
        .load_b(lb2), .load_s(ls2), .disp_sel(ds2), .busy(busy2),
        .ovf(ovf2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = 4'($urandom);
    endtask

    function automatic logic [31:0] pack(input int q[$]);
        logic [31:0] v = 0;
        foreach (q[i]) v = v * 16 + 32'(q[i]);
        return v;
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        m_ovf = 1'b0;
        mode  = 0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".opa"}, 32'(opa), pack(qa));
        chk({tag, ".opb"}, 32'(opb), pack(qb));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".disp"}, 32'(disp_sel), 32'(mode));
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    // entered right after '=' has been accepted; gap = idle WAIT cycles before s_done
    task automatic run_seq(input string tag, input int gap);
        chk({tag, ".la1"}, 32'(load_a), 1);
        chk({tag, ".lb1"}, 32'(load_b), 0);
        chk({tag, ".busy1"}, 32'(busy), 1);
        tick();
        chk({tag, ".la2"}, 32'(load_a), 0);
        chk({tag, ".lb2"}, 32'(load_b), 1);
        chk({tag, ".ls2"}, 32'(load_s), 0);
        tick();
        chk({tag, ".lb3"}, 32'(load_b), 0);
        chk({tag, ".ls3"}, 32'(load_s), 1);
        tick();
        chk({tag, ".ls4"}, 32'(load_s), 0);
        chk({tag, ".busyw"}, 32'(busy), 1);
        chk({tag, ".dispw"}, 32'(disp_sel), 1);
        repeat (gap) tick();
        chk({tag, ".stillw"}, 32'(busy), 1);
        s_done = 1'b1;
        tick();
        s_done = 1'b0;
        chk({tag, ".show"}, 32'(disp_sel), 2);
        chk({tag, ".busys"}, 32'(busy), 0);
    endtask

    initial begin
        model_clear();
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst.opa", 32'(opa), 0);
        chk("rst.strobes", {29'd0, load_a, load_b, load_s}, 0);
        chk("rst.flags", {29'd0, busy, ovf, err}, 0);
        chk("rst.disp", 32'(disp_sel), 0);
        rst = 1'b1;
        tick();
        chk_model("idle");

        // 1 2 + 3 =, s_done five cycles after load_s
        press(4'd1); press(4'd2);
        chk("a12.opa", 32'(opa), 32'h012);
        press(K_ADD);
        chk("a12.disp", 32'(disp_sel), 1);
        press(4'd3);
        chk("a12.opb", 32'(opb), 32'h003);
        press(K_EQ);
        run_seq("seq1", 4);
        chk("seq1.opa", 32'(opa), 32'h012);
        chk("seq1.opb", 32'(opb), 32'h003);
        press(4'd4);
        chk("show.dig.opa", 32'(opa), 32'h004);
        chk("show.dig.opb", 32'(opb), 0);
        chk("show.dig.disp", 32'(disp_sel), 0);
        press(K_CLR);

        // overflow
        press(4'd9); press(4'd8); press(4'd7);
        chk("ovf.pre", 32'(ovf), 0);
        press(4'd6);
        chk("ovf.opa", 32'(opa), 32'h987);
        chk("ovf.flag", 32'(ovf), 1);
        press(K_CLR);
        chk("ovf.clr", 32'(ovf), 0);
        chk("ovf.clropa", 32'(opa), 0);

        // '=' in ENTA and '+' in ENTB are ignored
        press(K_EQ);
        chk("eqA.disp", 32'(disp_sel), 0);
        chk("eqA.busy", {30'd0, busy, load_a}, 0);
        press(K_ADD); press(K_ADD);
        chk("addB.disp", 32'(disp_sel), 1);
        chk("addB.busy", {30'd0, busy, load_a}, 0);
        press(K_CLR);

        // clear during LDB
        press(4'd5); press(K_ADD); press(4'd6); press(K_EQ);
        tick();
        chk("clrB.lb", 32'(load_b), 1);
        press(K_CLR);
        chk("clrB.ls", 32'(load_s), 0);
        chk("clrB.ops", {opa, opb}, 0);
        chk("clrB.disp", 32'(disp_sel), 0);
        tick(); tick();
        chk("clrB.ls2", {30'd0, load_s, busy}, 0);

        // s_done in LDS is ignored, but honoured on the first WAIT cycle
        press(4'd2); press(K_ADD); press(4'd2); press(K_EQ);
        tick();
        s_done = 1'b1;
        tick();
        chk("sd.lds", 32'(load_s), 1);
        tick();
        chk("sd.wait1", 32'(busy), 1);
        tick();
        s_done = 1'b0;
        chk("sd.show", 32'(disp_sel), 2);
        press(K_CLR);

        // timeout of the TIMEOUT=4 instance
        press(4'd1); press(K_ADD); press(4'd2); press(K_EQ);
        tick(); tick(); tick();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("tmo.c%0d", i), {30'd0, err2, busy2}, 32'b01);
            tick();
        end
        chk("tmo.err", 32'(err2), 1);
        chk("tmo.disp", 32'(ds2), 2);
        press(K_EQ); press(4'd7);
        chk("tmo.hold", 32'(err2), 1);
        chk("tmo.holdop", {opa2, opb2}, {12'h001, 12'h002});
        press(K_CLR);
        chk("tmo.clr", {29'd0, err2, ds2}, 0);

        // s_done coinciding with the timeout wins
        press(4'd1); press(K_ADD); press(4'd2); press(K_EQ);
        repeat (6) tick();
        s_done2 = 1'b1;
        tick();
        s_done2 = 1'b0;
        chk("tie.show", {29'd0, err2, ds2}, 32'b010);
        tick();
        chk("tie.stay", 32'(ds2), 2);
        press(K_CLR);

        // asynchronous reset between load_b and load_s
        press(4'd1); press(K_ADD); press(4'd2); press(K_EQ);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst.lb", 32'(load_b), 0);
        chk("arst.ops", {opa, opb}, 0);
        tick();
        chk("arst.ls", {30'd0, load_s, busy}, 0);
        rst = 1'b1;
        tick();
        chk("arst.after", {29'd0, load_s, load_b, load_a}, 0);

        // reset mid-WAIT then key 5
        press(4'd3); press(K_ADD); press(4'd4); press(K_EQ);
        repeat (4) tick();
        rst = 1'b0;
        #1;
        chk("wrst.ops", {opa, opb}, 0);
        chk("wrst.flags", {25'd0, load_a, load_b, load_s, busy, ovf, err, 1'b0}, 0);
        chk("wrst.disp", 32'(disp_sel), 0);
        tick();
        rst = 1'b1;
        press(4'd5);
        chk("wrst.opa5", 32'(opa), 32'h005);
        chk("wrst.disp5", 32'(disp_sel), 0);
        press(K_CLR);

        // random keys against the digit-list model
        model_clear();
        for (int n = 0; n < 150; n++) begin
            int r;
            logic [3:0] k;
            r = int'($urandom_range(0, 99));
            if (r < 55)      k = 4'($urandom_range(0, 9));
            else if (r < 67) k = K_ADD;
            else if (r < 79) k = K_EQ;
            else if (r < 85) k = K_CLR;
            else if (r < 95) k = 4'($urandom_range(13, 15));
            else begin
                tick();
                chk_model($sformatf("rnd%0d.idle", n));
                continue;
            end
            press(k);
            if (k == K_CLR) begin
                model_clear();
            end else if (mode == 0) begin
                if (k <= 4'd9) begin
                    if (qa.size() < NDIG) qa.push_back(int'(k));
                    else m_ovf = 1'b1;
                end else if (k == K_ADD) mode = 1;
            end else if (mode == 1) begin
                if (k <= 4'd9) begin
                    if (qb.size() < NDIG) qb.push_back(int'(k));
                    else m_ovf = 1'b1;
                end else if (k == K_EQ) begin
                    run_seq($sformatf("rnd%0d", n), int'($urandom_range(0, 6)));
                    mode = 2;
                end
            end else if (k <= 4'd9) begin
                model_clear();
                qa.push_back(int'(k));
            end
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
